// File: rtl/mux_2level_ccff_shadow.sv
// Two-level one-hot routing mux with a serial configuration chain and a shadow register.
// Only a validated commit updates the active selection, so live routing never glitches.
module mux_2level_ccff_shadow #(
    parameter  int NUM_INPUTS = 20,
    parameter  int BASIS_SIZE = 5,
    localparam int NUM_GROUPS = (NUM_INPUTS + BASIS_SIZE - 1) / BASIS_SIZE,
    localparam int MEM_SIZE   = BASIS_SIZE + NUM_GROUPS,
    localparam int CNT_W      = $clog2(MEM_SIZE + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  ccff_head,
    input  logic                  shift_en,
    input  logic                  commit,
    input  logic [NUM_INPUTS-1:0] in,
    output logic                  out,
    output logic                  ccff_tail,
    output logic                  cfg_valid,
    output logic                  cfg_error,
    output logic [CNT_W-1:0]      bit_count
);

    localparam logic [CNT_W-1:0] MEM_CNT = CNT_W'(MEM_SIZE);
    localparam int PAD_W = NUM_GROUPS * BASIS_SIZE;

    logic [MEM_SIZE-1:0]   sr_q, sr_d;
    logic [MEM_SIZE-1:0]   active_q, active_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [BASIS_SIZE-1:0] l1_field;
    logic [NUM_GROUPS-1:0] l2_field;
    logic                  range_ok;
    logic                  sr_legal;

    logic [PAD_W-1:0]      in_pad;
    logic [NUM_GROUPS-1:0] grp_out;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sr_q     <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sr_q     <= sr_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Legality of the word currently sitting in the chain
    always_comb begin
        l1_field = sr_q[BASIS_SIZE-1:0];
        l2_field = sr_q[MEM_SIZE-1:BASIS_SIZE];
        range_ok = 1'b0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int b = 0; b < BASIS_SIZE; b++) begin
                if (g * BASIS_SIZE + b < NUM_INPUTS) begin
                    range_ok = range_ok | (l1_field[b] & l2_field[g]);
                end
            end
        end
        sr_legal = (cnt_q == MEM_CNT) && $onehot(l1_field) && $onehot(l2_field) && range_ok;
    end

    always_comb begin
        sr_d     = sr_q;
        active_d = active_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        if (shift_en) begin
            sr_d = {sr_q[MEM_SIZE-2:0], ccff_head};
            if (cnt_q != MEM_CNT) begin
                cnt_d = cnt_q + 1'b1;
            end
            // A commit racing a shift would latch a half-moved word, so it is refused
            if (commit) begin
                err_d = 1'b1;
            end
        end else if (commit) begin
            cnt_d = '0;
            if (sr_legal) begin
                active_d = sr_q;
                valid_d  = 1'b1;
                err_d    = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        in_pad                 = '0;
        in_pad[NUM_INPUTS-1:0] = in;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_out[g] = 1'b0;
            for (int b = 0; b < BASIS_SIZE; b++) begin
                grp_out[g] = grp_out[g] | (in_pad[g * BASIS_SIZE + b] & active_q[b]);
            end
        end
        out = valid_q & (|(grp_out & active_q[MEM_SIZE-1:BASIS_SIZE]));
    end

    assign ccff_tail = sr_q[MEM_SIZE-1];
    assign cfg_valid = valid_q;
    assign cfg_error = err_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_mux_2level_ccff_shadow.sv
// Bench for mux_2level_ccff_shadow: two chained instances against a bit-history reference model.
module tb_mux_2level_ccff_shadow;

    localparam int N  = 20;
    localparam int B  = 5;
    localparam int G  = 4;
    localparam int M  = 9;
    localparam int CW = 4;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          ccff_head;
    logic          shift_en;
    logic          commit;
    logic [N-1:0]  in_v;
    logic          out_a, out_b, tail_a, tail_b;
    logic          valid_a, valid_b, err_a, err_b;
    logic [CW-1:0] cnt_a, cnt_b;

    always #5 prog_clk = ~prog_clk;

    mux_2level_ccff_shadow #(.NUM_INPUTS(N), .BASIS_SIZE(B)) u_a (
        .prog_clk(prog_clk), .pReset(pReset), .ccff_head(ccff_head),
        .shift_en(shift_en), .commit(commit), .in(in_v), .out(out_a),
        .ccff_tail(tail_a), .cfg_valid(valid_a), .cfg_error(err_a), .bit_count(cnt_a)
    );

    mux_2level_ccff_shadow #(.NUM_INPUTS(N), .BASIS_SIZE(B)) u_b (
        .prog_clk(prog_clk), .pReset(pReset), .ccff_head(tail_a),
        .shift_en(shift_en), .commit(commit), .in(in_v), .out(out_b),
        .ccff_tail(tail_b), .cfg_valid(valid_b), .cfg_error(err_b), .bit_count(cnt_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // h[0] is the newest bit shifted into the pair; instance k holds h[9k .. 9k+8]
    bit h [2*M];
    int m_cnt;
    bit m_valid [2];
    bit m_err   [2];
    int m_sel   [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] word_of(input int k);
        logic [M-1:0] w;
        for (int i = 0; i < M; i++) w[i] = h[k*M + i];
        return w;
    endfunction

    function automatic bit decode(input logic [M-1:0] w, output int idx);
        int n1 = 0, n2 = 0, b = 0, g = 0;
        for (int i = 0; i < B; i++) if (w[i]) begin n1++; b = i; end
        for (int i = 0; i < G; i++) if (w[B+i]) begin n2++; g = i; end
        idx = g * B + b;
        return (n1 == 1) && (n2 == 1) && (idx < N);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2*M; i++) h[i] = 1'b0;
        m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_err[k] = 1'b0; m_sel[k] = 0;
        end
    endtask

    task automatic model_edge(input bit sh, input bit hd, input bit cm);
        int idx;
        if (sh) begin
            for (int i = 2*M-1; i > 0; i--) h[i] = h[i-1];
            h[0] = hd;
            if (m_cnt < M) m_cnt++;
            if (cm) begin m_err[0] = 1'b1; m_err[1] = 1'b1; end
        end else if (cm) begin
            for (int k = 0; k < 2; k++) begin
                if (m_cnt == M && decode(word_of(k), idx)) begin
                    m_sel[k] = idx; m_valid[k] = 1'b1; m_err[k] = 1'b0;
                end else begin
                    m_err[k] = 1'b1;
                end
            end
            m_cnt = 0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "/out_a"},   32'(out_a),   32'(m_valid[0] ? in_v[m_sel[0]] : 1'b0));
        check({tag, "/out_b"},   32'(out_b),   32'(m_valid[1] ? in_v[m_sel[1]] : 1'b0));
        check({tag, "/valid_a"}, 32'(valid_a), 32'(m_valid[0]));
        check({tag, "/valid_b"}, 32'(valid_b), 32'(m_valid[1]));
        check({tag, "/err_a"},   32'(err_a),   32'(m_err[0]));
        check({tag, "/err_b"},   32'(err_b),   32'(m_err[1]));
        check({tag, "/cnt_a"},   32'(cnt_a),   32'(m_cnt));
        check({tag, "/cnt_b"},   32'(cnt_b),   32'(m_cnt));
        check({tag, "/tail_a"},  32'(tail_a),  32'(h[M-1]));
        check({tag, "/tail_b"},  32'(tail_b),  32'(h[2*M-1]));
    endtask

    task automatic step(input string tag, input bit sh, input bit hd, input bit cm);
        @(negedge prog_clk);
        shift_en = sh; ccff_head = hd; commit = cm;
        in_v = N'($urandom);
        #1 check_state(tag);
        @(posedge prog_clk);
        #1 model_edge(sh, hd, cm);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0);
    endtask

    // Shifts MSB first so that the word ends up with w[i] in sr[i]
    task automatic shift_word(input string tag, input logic [M-1:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) step(tag, 1'b1, w[i], 1'b0);
    endtask

    task automatic probe(input string tag, input logic [N-1:0] v);
        @(negedge prog_clk);
        shift_en = 1'b0; commit = 1'b0; in_v = v;
        #1 check_state(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge prog_clk);
        #2 pReset = 1'b1;
        model_reset();
        #1 check_state(tag);
        @(negedge prog_clk);
        pReset = 1'b0; shift_en = 1'b0; commit = 1'b0;
    endtask

    function automatic logic [M-1:0] make_word(input int b, input int g);
        logic [M-1:0] w = '0;
        w[b]     = 1'b1;
        w[B + g] = 1'b1;
        return w;
    endfunction

    initial begin
        logic [M-1:0] wa, wb;
        pReset = 1'b1; ccff_head = 1'b0; shift_en = 1'b0; commit = 1'b0;
        in_v = 20'hFFFFF;
        model_reset();
        #1 check_state("reset");
        @(negedge prog_clk);
        pReset = 1'b0;

        // Stream 0,1,0,0,0,1,0,0,0 selects in[13] in the first instance
        wa = 9'b0_1000_1000;
        shift_word("load13", wa, M);
        step("commit13", 1'b0, 1'b0, 1'b1);
        probe("sel13_hi", 20'(1 << 13));
        probe("sel13_lo", ~20'(1 << 13));
        idle("idle13");

        // Reload with in[2]: out keeps following in[13] while shifting
        shift_word("load2", make_word(2, 0), M);
        step("commit2", 1'b0, 1'b0, 1'b1);
        probe("sel2_hi", 20'(1 << 2));

        // Short load and a two-hot level-1 field are both rejected
        shift_word("short", make_word(4, 3), M - 1);
        step("commit_short", 1'b0, 1'b0, 1'b1);
        shift_word("twohot", make_word(1, 1) | 9'b0_0000_1000, M);
        step("commit_twohot", 1'b0, 1'b0, 1'b1);
        idle("after_reject");

        // Chained load: first nine bits land in the downstream instance
        wb = make_word(3, 1);
        wa = make_word(0, 3);
        shift_word("chain_b", wb, M);
        shift_word("chain_a", wa, M);
        step("chain_commit", 1'b0, 1'b0, 1'b1);
        probe("chain_b8", 20'(1 << 8));
        probe("chain_a15", 20'(1 << 15));

        // Commit coinciding with a shift
        step("shift_commit", 1'b1, 1'b1, 1'b1);
        idle("after_sc");

        // Asynchronous reset in the middle of a load, then a normal load
        shift_word("pre_reset", make_word(1, 2), 5);
        async_reset("async_reset");
        shift_word("post_b", make_word(4, 0), M);
        shift_word("post_a", make_word(1, 2), M);
        step("post_commit", 1'b0, 1'b0, 1'b1);
        probe("post_a11", 20'(1 << 11));

        for (int it = 0; it < 80; it++) begin
            int mode = int'($urandom_range(0, 9));
            if (mode < 4) begin
                wb = make_word(int'($urandom_range(0, B-1)), int'($urandom_range(0, G-1)));
                wa = make_word(int'($urandom_range(0, B-1)), int'($urandom_range(0, G-1)));
                if (mode == 3) wa[$urandom_range(0, M-1)] ^= 1'b1;
                shift_word("rnd_b", wb, M);
                shift_word("rnd_a", wa, M);
                step("rnd_commit", 1'b0, 1'b0, 1'b1);
            end else if (mode < 9) begin
                step("rnd_op", 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            end else begin
                async_reset("rnd_reset");
            end
        end
        idle("final");
        probe("final_probe", N'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
